// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: opcodes, ALU ops,
// datapath mux selects and the sequencing state enum.
package mips_ctrl_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned ALUOP_W  = 3;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned STATE_W  = 4;

  localparam logic [OP_W-1:0] R_TYPE = 6'h00;
  localparam logic [OP_W-1:0] J      = 6'h02;
  localparam logic [OP_W-1:0] BEQ    = 6'h04;
  localparam logic [OP_W-1:0] BNE    = 6'h05;
  localparam logic [OP_W-1:0] ADDI   = 6'h08;
  localparam logic [OP_W-1:0] ORI    = 6'h0D;
  localparam logic [OP_W-1:0] LW     = 6'h23;
  localparam logic [OP_W-1:0] SW     = 6'h2B;

  localparam logic [ALUOP_W-1:0] ALU_NONE  = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b100;
  localparam logic [ALUOP_W-1:0] ALU_OR    = 3'b101;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = 3'b111;

  localparam logic [SEL_W-1:0] SRCB_RT      = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    I_EXEC    = 4'd8,
    I_WB      = 4'd9,
    BRANCH    = 4'd10,
    JUMP      = 4'd11
  } ctrl_state_t;

  // True for every opcode the control sequences; anything else is trapped in DECODE.
  function automatic logic opSupported(input logic [OP_W-1:0] o);
    case (o)
      R_TYPE, J, BEQ, BNE, ADDI, ORI, LW, SW: opSupported = 1'b1;
      default:                                opSupported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mctrl_perf_counters.sv
// Free-running cycle and retired-instruction counters; compiled only when
// MCTRL_PERF_CNT_EN is defined.
`ifdef MCTRL_PERF_CNT_EN
module mctrl_perf_counters #(
  parameter int unsigned PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instrDone,
  output logic [PERF_W-1:0] cycleCnt,
  output logic [PERF_W-1:0] instrCnt
);

  // Both counters wrap naturally at 2^PERF_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycleCnt <= '0;
      instrCnt <= '0;
    end else begin
      cycleCnt <= cycleCnt + PERF_W'(1);
      if (instrDone) instrCnt <= instrCnt + PERF_W'(1);
    end
  end

endmodule
`endif

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencing FSM driving the shared-memory/shared-ALU datapath.
// Define MCTRL_PERF_CNT_EN to add the cycle_cnt/instr_cnt performance counters.
module multicycle_control
  import mips_ctrl_pkg::*;
`ifdef MCTRL_PERF_CNT_EN
  #(parameter int unsigned PERF_W = 32)
`endif
(
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCondEQ,
  output logic               PCWriteCondNE,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [SEL_W-1:0]   ALUSrcB,
  output logic [SEL_W-1:0]   PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               illegal_op,
  output logic               instr_done
`ifdef MCTRL_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]  cycle_cnt,
  output logic [PERF_W-1:0]  instr_cnt
`endif
);

  ctrl_state_t        state;
  ctrl_state_t        nextState;
  logic [ALUOP_W-1:0] immAluOp;

  // ADDI and ORI share the immediate path; only the ALU function differs.
  assign immAluOp = (op == ORI) ? ALU_OR : ALU_ADD;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= nextState;
  end

  always_comb begin
    nextState = FETCH;
    case (state)
      FETCH:     nextState = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          LW, SW:   nextState = MEM_ADDR;
          R_TYPE:   nextState = R_EXEC;
          ADDI, ORI: nextState = I_EXEC;
          BEQ, BNE: nextState = BRANCH;
          J:        nextState = JUMP;
          default:  nextState = FETCH;
        endcase
      end
      MEM_ADDR:  nextState = (op == LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:  nextState = mem_ready ? MEM_WB : MEM_READ;
      MEM_WRITE: nextState = mem_ready ? FETCH : MEM_WRITE;
      R_EXEC:    nextState = R_WB;
      I_EXEC:    nextState = I_WB;
      default:   nextState = FETCH;
    endcase
  end

  // Moore decode; only the memory-handshake strobes look at mem_ready.
  always_comb begin
    PCWrite       = 1'b0;
    PCWriteCondEQ = 1'b0;
    PCWriteCondNE = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = SRCB_RT;
    PCSource      = PCSRC_ALU;
    ALUOp         = ALU_NONE;
    illegal_op    = 1'b0;
    instr_done    = 1'b0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        ALUOp   = ALU_ADD;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE: begin
        ALUSrcB    = SRCB_IMM_SH2;
        ALUOp      = ALU_ADD;
        illegal_op = ~opSupported(op);
        instr_done = ~opSupported(op);
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALU_ADD;
      end
      MEM_READ: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      MEM_WB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WRITE: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
      end
      R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
      end
      R_WB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = immAluOp;
      end
      I_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        ALUOp      = immAluOp;
      end
      BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUOp         = ALU_SUB;
        PCSource      = PCSRC_ALUOUT;
        PCWriteCondEQ = (op == BEQ);
        PCWriteCondNE = (op == BNE);
        instr_done    = 1'b1;
      end
      JUMP: begin
        PCSource   = PCSRC_JUMP;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MCTRL_PERF_CNT_EN
  mctrl_perf_counters #(.PERF_W(PERF_W)) uPerf (
    .clk      (clk),
    .reset    (reset),
    .instrDone(instr_done),
    .cycleCnt (cycle_cnt),
    .instrCnt (instr_cnt)
  );
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: instruction table with a
// completion scoreboard, plus directed reset and counter sequences.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;
  logic       PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite;
  logic       IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic       illegal_op, instr_done;
`ifdef MCTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCondEQ(PCWriteCondEQ), .PCWriteCondNE(PCWriteCondNE),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp),
    .illegal_op(illegal_op), .instr_done(instr_done)
`ifdef MCTRL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    int         lat;
    int         dataCyc;
    int         regWr;
    logic       regDst, memtoReg, memWrite, pcWrite, condEq, condNe, illegal;
    logic [1:0] pcSrc;
    logic [2:0] aluOp;
  } exp_t;

  typedef struct {
    logic [5:0] op;
    int         fw;
    int         mw;
    exp_t       e;
  } vec_t;

  vec_t vecs[$];
  exp_t sbQ[$];
  int   total = 0;
  int   bad   = 0;
  bit   monOn = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic addVec(input logic [5:0] o, input int fw, input int mw, input int lat,
                        input int dc, input int rw, input logic dst, input logic m2r,
                        input logic mwr, input logic pcw, input logic eq, input logic ne,
                        input logic [1:0] pcs, input logic [2:0] alu, input logic ill);
    vec_t v;
    v.op = o; v.fw = fw; v.mw = mw;
    v.e.idx = vecs.size(); v.e.lat = lat; v.e.dataCyc = dc; v.e.regWr = rw;
    v.e.regDst = dst; v.e.memtoReg = m2r; v.e.memWrite = mwr; v.e.pcWrite = pcw;
    v.e.condEq = eq; v.e.condNe = ne; v.e.illegal = ill; v.e.pcSrc = pcs; v.e.aluOp = alu;
    vecs.push_back(v);
  endtask

  // Drive one instruction from FETCH to its instr_done; fw/mw stall the fetch/data access.
  task automatic runInstr(input vec_t v);
    int f = v.fw;
    int m = v.mw;
    int n = 0;
    bit done = 1'b0;
    sbQ.push_back(v.e);
    op = v.op;
    while (!done && n < 40) begin
      if ((MemRead || MemWrite) && !IorD && f > 0) begin
        mem_ready = 1'b0; f--;
      end else if ((MemRead || MemWrite) && IorD && m > 0) begin
        mem_ready = 1'b0; m--;
      end else begin
        mem_ready = 1'b1;
      end
      @(negedge clk);
      done = instr_done;
      n++;
      @(posedge clk); #1;
    end
    if (!done) check($sformatf("timeout[%0d]", v.e.idx), 32'(n), 32'd0);
  endtask

  // Scoreboard side: count per-instruction activity, compare on instr_done.
  int cyc, dataCyc, regWr;
  bit afterDone;
  always @(negedge clk) begin
    exp_t e;
    if (reset || !monOn) begin
      cyc = 0; dataCyc = 0; regWr = 0; afterDone = 1'b0;
    end else begin
      if (afterDone) begin
        check("fetch_after_done", 32'({MemRead, IorD, ALUSrcB}), 32'(4'b1001));
        afterDone = 1'b0;
      end
      cyc++;
      if (IorD && (MemRead || MemWrite)) dataCyc++;
      if (RegWrite) regWr++;
      if (instr_done) begin
        if (sbQ.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sbQ.pop_front();
          check($sformatf("latency[%0d]", e.idx), 32'(cyc), 32'(e.lat));
          check($sformatf("data_cycles[%0d]", e.idx), 32'(dataCyc), 32'(e.dataCyc));
          check($sformatf("regwrite_cycles[%0d]", e.idx), 32'(regWr), 32'(e.regWr));
          check($sformatf("final_ctrl[%0d]", e.idx),
                32'({RegDst, MemtoReg, MemWrite, PCWrite, PCWriteCondEQ, PCWriteCondNE,
                     illegal_op, PCSource, ALUOp}),
                32'({e.regDst, e.memtoReg, e.memWrite, e.pcWrite, e.condEq, e.condNe,
                     e.illegal, e.pcSrc, e.aluOp}));
        end
        cyc = 0; dataCyc = 0; regWr = 0; afterDone = 1'b1;
      end
    end
  end

  initial begin
    reset = 1'b1; mem_ready = 1'b1; op = 6'h00;

    //      op     fw mw lat dc rw dst m2r mwr pcw eq ne pcs    alu     ill
    addVec(6'h08, 0, 0, 4,  0, 1, 0,  0,  0,  0,  0, 0, 2'b00, 3'b100, 0); // 0 ADDI
    addVec(6'h0D, 0, 0, 4,  0, 1, 0,  0,  0,  0,  0, 0, 2'b00, 3'b101, 0); // 1 ORI
    addVec(6'h00, 0, 0, 4,  0, 1, 1,  0,  0,  0,  0, 0, 2'b00, 3'b000, 0); // 2 R-type
    addVec(6'h23, 0, 2, 7,  3, 1, 0,  1,  0,  0,  0, 0, 2'b00, 3'b000, 0); // 3 LW, 2 waits
    addVec(6'h23, 1, 0, 6,  1, 1, 0,  1,  0,  0,  0, 0, 2'b00, 3'b000, 0); // 4 LW, fetch wait
    addVec(6'h2B, 0, 0, 4,  1, 0, 0,  0,  1,  0,  0, 0, 2'b00, 3'b000, 0); // 5 SW
    addVec(6'h2B, 2, 3, 9,  4, 0, 0,  0,  1,  0,  0, 0, 2'b00, 3'b000, 0); // 6 SW, waits
    addVec(6'h04, 0, 0, 3,  0, 0, 0,  0,  0,  0,  1, 0, 2'b01, 3'b001, 0); // 7 BEQ
    addVec(6'h05, 0, 0, 3,  0, 0, 0,  0,  0,  0,  0, 1, 2'b01, 3'b001, 0); // 8 BNE
    addVec(6'h02, 0, 0, 3,  0, 0, 0,  0,  0,  1,  0, 0, 2'b10, 3'b000, 0); // 9 J
    addVec(6'h3F, 0, 0, 2,  0, 0, 0,  0,  0,  0,  0, 0, 2'b00, 3'b100, 1); // 10 illegal
    addVec(6'h01, 1, 0, 3,  0, 0, 0,  0,  0,  0,  0, 0, 2'b00, 3'b100, 1); // 11 illegal

    @(posedge clk); #1;
    check("reset_fetch_ctrl",
          32'({MemRead, IorD, MemWrite, RegWrite, ALUSrcB, ALUOp, instr_done, IRWrite, PCWrite}),
          32'({1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 3'b100, 1'b0, 1'b1, 1'b1}));
    mem_ready = 1'b0; #1;
    check("fetch_stall_strobes", 32'({IRWrite, PCWrite, MemRead}), 32'(3'b001));

    @(posedge clk); #1;
    reset = 1'b0; monOn = 1'b1;
    for (int i = 0; i < vecs.size(); i++) runInstr(vecs[i]);
    monOn = 1'b0;
    check("sb_empty", 32'(sbQ.size()), 32'd0);

    // Reset landing in a stalled store must kill MemWrite at once.
    op = 6'h2B; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    check("sw_stalled", 32'({MemWrite, IorD, instr_done}), 32'(3'b110));
    #2 reset = 1'b1; #1;
    check("reset_kills_write", 32'({MemWrite, MemRead, IorD, RegWrite}), 32'(4'b0100));
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b1; #1;
    check("post_reset_fetch", 32'({MemRead, IorD, IRWrite, MemWrite}), 32'(4'b1010));

`ifdef MCTRL_PERF_CNT_EN
    reset = 1'b1;
    @(posedge clk); #1;
    check("perf_reset", 32'({cycle_cnt, instr_cnt} == 64'd0), 32'd1);
    reset = 1'b0; monOn = 1'b1;
    runInstr(vecs[2]);
    runInstr(vecs[9]);
    runInstr(vecs[5]);
    monOn = 1'b0;
    check("perf_instr_cnt", instr_cnt, 32'd3);
    check("perf_cycle_cnt", cycle_cnt, 32'd11);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencing FSM for the MIPS core. It replaces the single-cycle opcode decoder when the datapath shares one memory and one ALU across cycles.
- Walks each instruction through fetch, decode, execute, memory and writeback, and drives every datapath mux and enable.
- Sits between the instruction register opcode field and the shared datapath. Stalls on a memory-ready handshake.

Parameters:
- PERF_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces FETCH
- op  in  6  opcode, IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCondEQ  out  1  PC load if ALU zero=1 (BEQ)
- PCWriteCondNE  out  1  PC load if ALU zero=0 (BNE)
- IorD  out  1  memory address mux: 0=PC, 1=ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  write-back data mux: 0=ALUOut, 1=MDR
- RegDst  out  1  destination register mux: 0=rt, 1=rd
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A mux: 0=PC, 1=rs
- ALUSrcB  out  2  ALU B mux: 00=rt, 01=const 4, 10=signext imm, 11=signext imm<<2
- PCSource  out  2  PC mux: 00=ALU, 01=ALUOut, 10=jump target
- ALUOp  out  3  ALU op: 100=add, 101=or, 001=sub, 111=funct decode
- illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode
- instr_done  out  1  one-cycle pulse in the final state of each instruction

Behaviour:
- Supported opcodes:
  - R-type 0x00
  - J 0x02
  - BEQ 0x04
  - BNE 0x05
  - ADDI 0x08
  - ORI 0x0D
  - LW 0x23
  - SW 0x2B
- State register is 4 bits, async reset to FETCH. Outputs are a Moore decode of state, except that the mem_ready-gated strobes below also depend on mem_ready.
- Every output not listed for a state is 0.
- FETCH:
  - IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=100, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=100 (precomputes branch target).
  - Next state by op:
    - LW/SW -> MEM_ADDR
    - R-type -> R_EXEC
    - ADDI/ORI -> I_EXEC
    - BEQ/BNE -> BRANCH
    - J -> JUMP
    - any other op -> FETCH with illegal_op=1 and instr_done=1.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=100. Next state is MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: IorD=1, MemRead=1. Holds until mem_ready=1, then goes to MEM_WB.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Next state FETCH.
- MEM_WRITE: IorD=1, MemWrite=1. Holds until mem_ready=1; on that cycle instr_done=1 and next state is FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=111. Next state R_WB.
- R_WB: RegDst=1, RegWrite=1, instr_done=1. Next state FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=100 for ADDI or 101 for ORI. Next state I_WB.
- I_WB: RegDst=0, RegWrite=1, instr_done=1. ALUOp is held at the I_EXEC value. Next state FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01.
  - PCWriteCondEQ=1 for BEQ, PCWriteCondNE=1 for BNE.
  - instr_done=1. Next state FETCH.
- JUMP: PCSource=10, PCWrite=1, instr_done=1. Next state FETCH.
- Latency (cycles, with mem_ready always 1):
  - R-type/ADDI/ORI: 4
  - LW: 5
  - SW: 4
  - BEQ/BNE/J: 3
  - Each wait cycle with mem_ready=0 adds one cycle.
- op is sampled in DECODE and again in MEM_ADDR, I_EXEC, I_WB and BRANCH. The IR holds op stable because IRWrite is only asserted in FETCH.
- Reset mid-instruction: state goes to FETCH immediately (async). No write strobe survives reset beyond the reset edge.
- Unreachable state encodings: next state is FETCH, all outputs 0.

Optional Feature:
- Macro: MCTRL_PERF_CNT_EN.
- When defined:
  - Adds outputs cycle_cnt[PERF_W-1:0] and instr_cnt[PERF_W-1:0].
  - cycle_cnt increments every clock after reset.
  - instr_cnt increments on each instr_done pulse.
  - Both wrap modulo 2^PERF_W and reset to 0.
- When undefined: no counter ports and no counter logic.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode localparams (R_TYPE, J, BEQ, BNE, ADDI, ORI, LW, SW)
  - ALUOp codes (ALU_ADD=3'b100, ALU_OR=3'b101, ALU_SUB=3'b001, ALU_FUNCT=3'b111)
  - the state enum typedef ctrl_state_t
  - ALUSrcB and PCSource encodings.
- One sub-module, mctrl_perf_counters, instantiated only under MCTRL_PERF_CNT_EN.

Test Plan:
- ADDI (op=0x08), mem_ready=1 -> states FETCH, DECODE, I_EXEC, I_WB. ALUOp=100 in I_EXEC. RegWrite=1 and RegDst=0 in cycle 4. instr_done in cycle 4.
- LW (op=0x23), mem_ready low for 2 cycles in MEM_READ -> MemRead=1 and IorD=1 held for 3 cycles. MemtoReg=1 and RegWrite=1 in MEM_WB. Total 7 cycles.
- BNE (op=0x05) -> ALUOp=001, PCWriteCondNE=1, PCWriteCondEQ=0, PCSource=01 in cycle 3. Back in FETCH in cycle 4.
- Illegal op=0x3F -> illegal_op=1 and instr_done=1 in DECODE. Next state FETCH. No RegWrite or MemWrite asserted.
- reset asserted during MEM_WRITE with mem_ready=0 -> MemWrite drops immediately, state is FETCH. After release, first fetch has MemRead=1.
- With MCTRL_PERF_CNT_EN, run R-type, J, SW with mem_ready=1 -> instr_cnt=3, cycle_cnt=11.
